// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive watchdog on a cyclic traffic-lamp bus. It registers the lamp code, tracks the
//   current phase and how long it has been held, and reports illegal codes, illegal phase
//   order and dwell times outside [N-TOL, N+TOL].
//
// Ports
//   clk         in   1      rising-edge clock
//   reset_n     in   1      asynchronous active-low reset
//   light       in   3      lamp code, [2]=RED [1]=YELLOW [0]=GREEN, one-hot when legal
//   err_clr     in   1      synchronous clear of err_sticky / err_code
//   phase       out  2      0=SYNC 1=RED 2=GREEN 3=YELLOW
//   dwell       out  CNT_W  cycles the current phase has been held (saturating)
//   cycle_cnt   out  CNT_W  completed RED->GREEN->YELLOW->RED cycles (saturating)
//   err_pulse   out  1      one-cycle strobe per error event
//   err_sticky  out  1      set by any error until err_clr or reset
//   err_code    out  3      first error since clear: 0 none 1 code 2 order 3 short 4 long
module traffic_light_monitor #(
  parameter int unsigned RED_CYCLES    = 5,
  parameter int unsigned GREEN_CYCLES  = 4,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned TOL           = 0,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       light,
  input  logic             err_clr,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [2:0]       err_code
);

  localparam logic [1:0] PH_SYNC   = 2'd0;
  localparam logic [1:0] PH_RED    = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;
  localparam logic [1:0] PH_YELLOW = 2'd3;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CODE    = 3'd1;
  localparam logic [2:0] ERR_ORDER   = 3'd2;
  localparam logic [2:0] ERR_SHORT   = 3'd3;
  localparam logic [2:0] ERR_LONG    = 3'd4;

  // One extra bit so N+TOL and dwell+TOL never wrap.
  localparam logic [CNT_W:0] RED_N    = (CNT_W+1)'(RED_CYCLES);
  localparam logic [CNT_W:0] GREEN_N  = (CNT_W+1)'(GREEN_CYCLES);
  localparam logic [CNT_W:0] YELLOW_N = (CNT_W+1)'(YELLOW_CYCLES);
  localparam logic [CNT_W:0] TOL_N    = (CNT_W+1)'(TOL);

  logic [2:0]       light_q, light_prev_q;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             err_pulse_q;
  logic             err_sticky_q, err_sticky_d;
  logic [2:0]       err_code_q, err_code_d;

  logic             changed;
  logic             legal;
  logic [1:0]       code_phase;
  logic [1:0]       next_phase;
  logic [CNT_W:0]   n_sel;
  logic [CNT_W:0]   dwell_ext;
  logic             dwell_ok;
  logic             dwell_long;
  logic             err_ev;
  logic [2:0]       err_new;

  // Decode the registered lamp code into the phase it requests.
  always_comb begin
    code_phase = PH_SYNC;
    unique case (light_q)
      LAMP_RED:    code_phase = PH_RED;
      LAMP_GREEN:  code_phase = PH_GREEN;
      LAMP_YELLOW: code_phase = PH_YELLOW;
      default:     code_phase = PH_SYNC;
    endcase
  end

  // Legal successor and required dwell of the phase currently being tracked.
  always_comb begin
    next_phase = PH_SYNC;
    n_sel      = '0;
    case (phase_q)
      PH_RED: begin
        next_phase = PH_GREEN;
        n_sel      = RED_N;
      end
      PH_GREEN: begin
        next_phase = PH_YELLOW;
        n_sel      = GREEN_N;
      end
      PH_YELLOW: begin
        next_phase = PH_RED;
        n_sel      = YELLOW_N;
      end
      default: begin
        next_phase = PH_SYNC;
        n_sel      = '0;
      end
    endcase
  end

  assign changed    = (light_q != light_prev_q);
  assign legal      = (code_phase != PH_SYNC);
  assign dwell_ext  = {1'b0, dwell_q};
  assign dwell_ok   = (dwell_ext + TOL_N >= n_sel) && (dwell_ext <= n_sel + TOL_N);
  // Holding one more cycle would reach N+TOL+1.
  assign dwell_long = (dwell_ext == n_sel + TOL_N);

  always_comb begin
    phase_d = phase_q;
    dwell_d = dwell_q;
    cycle_d = cycle_q;
    err_ev  = 1'b0;
    err_new = ERR_NONE;

    if (phase_q == PH_SYNC) begin
      if (changed && legal) begin
        phase_d = code_phase;
        dwell_d = CNT_W'(1);
      end
    end else if (!changed) begin
      if (dwell_long) begin
        err_ev  = 1'b1;
        err_new = ERR_LONG;
      end else if (dwell_q != {CNT_W{1'b1}}) begin
        dwell_d = dwell_q + CNT_W'(1);
      end
    end else if (!legal) begin
      err_ev  = 1'b1;
      err_new = ERR_CODE;
    end else if (code_phase != next_phase) begin
      err_ev  = 1'b1;
      err_new = ERR_ORDER;
    end else if (!dwell_ok) begin
      err_ev  = 1'b1;
      err_new = ERR_SHORT;
    end else begin
      phase_d = code_phase;
      dwell_d = CNT_W'(1);
      if (phase_q == PH_YELLOW && cycle_q != {CNT_W{1'b1}}) begin
        cycle_d = cycle_q + CNT_W'(1);
      end
    end

    if (err_ev) begin
      phase_d = PH_SYNC;
      dwell_d = '0;
    end
  end

  // A new error on the same edge as err_clr wins over the clear.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_code_d   = err_code_q;
    if (err_clr) begin
      err_sticky_d = err_ev;
      err_code_d   = err_ev ? err_new : ERR_NONE;
    end else if (err_ev) begin
      err_sticky_d = 1'b1;
      if (err_code_q == ERR_NONE) begin
        err_code_d = err_new;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      light_q      <= 3'b000;
      light_prev_q <= 3'b000;
      phase_q      <= PH_SYNC;
      dwell_q      <= '0;
      cycle_q      <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      light_q      <= light;
      light_prev_q <= light_q;
      phase_q      <= phase_d;
      dwell_q      <= dwell_d;
      cycle_q      <= cycle_d;
      err_pulse_q  <= err_ev;
      err_sticky_q <= err_sticky_d;
      err_code_q   <= err_code_d;
    end
  end

  assign phase      = phase_q;
  assign dwell      = dwell_q;
  assign cycle_cnt  = cycle_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor
//   Directed, table-driven bench for traffic_light_monitor with default parameters
//   (RED 5, GREEN 4, YELLOW 2, TOL 0, CNT_W 8). Each table record holds the inputs driven
//   before an edge and the outputs expected just after it.
module tb_traffic_light_monitor;

  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] Z  = 3'b000;
  localparam logic [2:0] RY = 3'b110;

  typedef struct {
    logic [2:0] light;
    logic       clr;
    logic [1:0] ph;
    logic [7:0] dw;
    logic [7:0] cyc;
    logic       pulse;
    logic       sticky;
    logic [2:0] code;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic [2:0] light;
  logic       err_clr;
  logic [1:0] phase;
  logic [7:0] dwell;
  logic [7:0] cycle_cnt;
  logic       err_pulse;
  logic       err_sticky;
  logic [2:0] err_code;

  int checks;
  int failures;

  vec_t       vecs[$];
  logic [2:0] seq[$];

  traffic_light_monitor dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .light      (light),
    .err_clr    (err_clr),
    .phase      (phase),
    .dwell      (dwell),
    .cycle_cnt  (cycle_cnt),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [1:0] ph, input logic [7:0] dw,
                         input logic [7:0] cyc, input logic pulse, input logic sticky,
                         input logic [2:0] code);
    chk("phase", idx, {6'd0, phase}, {6'd0, ph});
    chk("dwell", idx, dwell, dw);
    chk("cycle_cnt", idx, cycle_cnt, cyc);
    chk("err_pulse", idx, {7'd0, err_pulse}, {7'd0, pulse});
    chk("err_sticky", idx, {7'd0, err_sticky}, {7'd0, sticky});
    chk("err_code", idx, {5'd0, err_code}, {5'd0, code});
  endtask

  task automatic add(input logic [2:0] l, input logic c, input logic [1:0] ph,
                     input logic [7:0] dw, input logic [7:0] cyc, input logic pulse,
                     input logic sticky, input logic [2:0] code);
    vec_t v;
    v.light  = l;
    v.clr    = c;
    v.ph     = ph;
    v.dw     = dw;
    v.cyc    = cyc;
    v.pulse  = pulse;
    v.sticky = sticky;
    v.code   = code;
    vecs.push_back(v);
  endtask

  function automatic logic [1:0] lamp_phase(input logic [2:0] l);
    if (l == R) return 2'd1;
    if (l == G) return 2'd2;
    if (l == Y) return 2'd3;
    return 2'd0;
  endfunction

  initial begin
    int run;
    int cyc;

    checks   = 0;
    failures = 0;

    // Three legal RED5/GREEN4/YELLOW2 cycles, then RED. The monitor sees each code one
    // edge after it is driven, so vector i reflects seq[i-1].
    for (int c = 0; c < 3; c++) begin
      repeat (5) seq.push_back(R);
      repeat (4) seq.push_back(G);
      repeat (2) seq.push_back(Y);
    end
    seq.push_back(R);
    seq.push_back(R);
    run = 0;
    cyc = 0;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == 0) begin
        add(seq[i], 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd0);
      end else begin
        if (i >= 2 && seq[i-1] == seq[i-2]) run++;
        else run = 1;
        if (i >= 2 && seq[i-1] == R && seq[i-2] == Y) cyc++;
        add(seq[i], 1'b0, lamp_phase(seq[i-1]), 8'(run), 8'(cyc), 1'b0, 1'b0, 3'd0);
      end
    end

    // Finish RED legally, then GREEN held only 3 cycles -> short dwell at YELLOW entry.
    add(R,  0, 1, 2, 3, 0, 0, 0);
    add(R,  0, 1, 3, 3, 0, 0, 0);
    add(R,  0, 1, 4, 3, 0, 0, 0);
    add(G,  0, 1, 5, 3, 0, 0, 0);
    add(G,  0, 2, 1, 3, 0, 0, 0);
    add(G,  0, 2, 2, 3, 0, 0, 0);
    add(Y,  0, 2, 3, 3, 0, 0, 0);
    add(Y,  0, 0, 0, 3, 1, 1, 3);
    add(Y,  0, 0, 0, 3, 0, 1, 3);
    add(R,  0, 0, 0, 3, 0, 1, 3);
    // Re-lock on RED together with err_clr, then RED overstays -> long dwell.
    add(R,  1, 1, 1, 3, 0, 0, 0);
    add(R,  0, 1, 2, 3, 0, 0, 0);
    add(R,  0, 1, 3, 3, 0, 0, 0);
    add(R,  0, 1, 4, 3, 0, 0, 0);
    add(R,  0, 1, 5, 3, 0, 0, 0);
    add(R,  0, 0, 0, 3, 1, 1, 4);
    add(R,  0, 0, 0, 3, 0, 1, 4);
    // Clear, lock on YELLOW, legal YELLOW->RED bumps cycle_cnt, then RED->YELLOW order error.
    add(Y,  1, 0, 0, 3, 0, 0, 0);
    add(Y,  0, 3, 1, 3, 0, 0, 0);
    add(R,  0, 3, 2, 3, 0, 0, 0);
    add(R,  0, 1, 1, 4, 0, 0, 0);
    add(R,  0, 1, 2, 4, 0, 0, 0);
    add(R,  0, 1, 3, 4, 0, 0, 0);
    add(R,  0, 1, 4, 4, 0, 0, 0);
    add(Y,  0, 1, 5, 4, 0, 0, 0);
    add(Y,  0, 0, 0, 4, 1, 1, 2);
    // Illegal code while in SYNC raises nothing; err_clr then clears.
    add(RY, 0, 0, 0, 4, 0, 1, 2);
    add(RY, 0, 0, 0, 4, 0, 1, 2);
    add(RY, 1, 0, 0, 4, 0, 0, 0);
    add(RY, 0, 0, 0, 4, 0, 0, 0);
    // GREEN held 3 then 000: illegal code beats short dwell, single pulse.
    add(G,  0, 0, 0, 4, 0, 0, 0);
    add(G,  0, 2, 1, 4, 0, 0, 0);
    add(G,  0, 2, 2, 4, 0, 0, 0);
    add(Z,  0, 2, 3, 4, 0, 0, 0);
    add(Z,  0, 0, 0, 4, 1, 1, 1);
    add(Z,  0, 0, 0, 4, 0, 1, 1);
    // err_clr coincident with a long-dwell error: new error wins, code becomes 4.
    add(R,  0, 0, 0, 4, 0, 1, 1);
    add(R,  0, 1, 1, 4, 0, 1, 1);
    add(R,  0, 1, 2, 4, 0, 1, 1);
    add(R,  0, 1, 3, 4, 0, 1, 1);
    add(R,  0, 1, 4, 4, 0, 1, 1);
    add(R,  0, 1, 5, 4, 0, 1, 1);
    add(R,  1, 0, 0, 4, 1, 1, 4);
    add(R,  0, 0, 0, 4, 0, 1, 4);
    // Enter GREEN so the reset below lands mid-phase.
    add(G,  0, 0, 0, 4, 0, 1, 4);
    add(G,  0, 2, 1, 4, 0, 1, 4);
    add(G,  0, 2, 2, 4, 0, 1, 4);

    // Reset and check the reset state.
    reset_n = 1'b0;
    light   = Z;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      light   = vecs[i].light;
      err_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      chk_all(i, vecs[i].ph, vecs[i].dw, vecs[i].cyc, vecs[i].pulse, vecs[i].sticky,
              vecs[i].code);
    end

    // Asynchronous reset between edges, mid-GREEN: outputs clear without a clock.
    #2;
    reset_n = 1'b0;
    #1;
    chk_all(1000, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd0);
    light   = R;
    err_clr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_edge1", 1001, {6'd0, phase}, 8'd0);
    @(posedge clk);
    #1;
    chk_all(1002, 2'd1, 8'd1, 8'd0, 1'b0, 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
